// File: rtl/inst_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_pkg
// Description : Mnemonic codes, MIPS opcode/func constants and loader states.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_pkg;

    // Mnemonic codes presented on in_op; 13..15 are illegal
    localparam logic [3:0] c_MN_NOP  = 4'd0;
    localparam logic [3:0] c_MN_ADD  = 4'd1;
    localparam logic [3:0] c_MN_SUB  = 4'd2;
    localparam logic [3:0] c_MN_AND  = 4'd3;
    localparam logic [3:0] c_MN_OR   = 4'd4;
    localparam logic [3:0] c_MN_SLT  = 4'd5;
    localparam logic [3:0] c_MN_LW   = 4'd6;
    localparam logic [3:0] c_MN_SW   = 4'd7;
    localparam logic [3:0] c_MN_ADDI = 4'd8;
    localparam logic [3:0] c_MN_ANDI = 4'd9;
    localparam logic [3:0] c_MN_J    = 4'd10;
    localparam logic [3:0] c_MN_BEQ  = 4'd11;
    localparam logic [3:0] c_MN_BNE  = 4'd12;

    // Primary opcodes, identical to those the control unit decodes
    localparam logic [5:0] c_OPC_RTYPE = 6'b000000;
    localparam logic [5:0] c_OPC_LW    = 6'b100011;
    localparam logic [5:0] c_OPC_SW    = 6'b101011;
    localparam logic [5:0] c_OPC_ADDI  = 6'b001000;
    localparam logic [5:0] c_OPC_ANDI  = 6'b001100;
    localparam logic [5:0] c_OPC_BEQ   = 6'b000100;
    localparam logic [5:0] c_OPC_BNE   = 6'b000101;
    localparam logic [5:0] c_OPC_J     = 6'b000010;

    // R-type function codes
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_LOAD  = 2'd1;
    localparam state_t c_ST_WRITE = 2'd2;
    localparam state_t c_ST_DONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Combinational mnemonic-to-MIPS word encoder with illegal flag.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder
    import inst_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_illegal
);

    always_comb begin
        o_word    = 32'h0;
        o_illegal = 1'b0;
        case (i_op)
            c_MN_NOP:  o_word = 32'h0;
            c_MN_ADD:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, c_FN_ADD};
            c_MN_SUB:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, c_FN_SUB};
            c_MN_AND:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, c_FN_AND};
            c_MN_OR:   o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, c_FN_OR};
            c_MN_SLT:  o_word = {c_OPC_RTYPE, i_rs, i_rt, i_rd, 5'b00000, c_FN_SLT};
            c_MN_LW:   o_word = {c_OPC_LW,   i_rs, i_rt, i_imm};
            c_MN_SW:   o_word = {c_OPC_SW,   i_rs, i_rt, i_imm};
            c_MN_ADDI: o_word = {c_OPC_ADDI, i_rs, i_rt, i_imm};
            c_MN_ANDI: o_word = {c_OPC_ANDI, i_rs, i_rt, i_imm};
            c_MN_J:    o_word = {c_OPC_J, i_target};
            c_MN_BEQ:  o_word = {c_OPC_BEQ,  i_rs, i_rt, i_imm};
            c_MN_BNE:  o_word = {c_OPC_BNE,  i_rs, i_rt, i_imm};
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Streams encoded instructions into instruction memory from 0.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
    import inst_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [31:0]       r_wdata;
    logic              r_last;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_illegal;

    inst_encoder u_encoder (
        .i_op      (in_op),
        .i_rs      (in_rs),
        .i_rt      (in_rt),
        .i_rd      (in_rd),
        .i_imm     (in_imm),
        .i_target  (in_target),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // Strobes decode straight from state so reset drops mem_we asynchronously
    assign in_ready  = (r_state == c_ST_LOAD);
    assign mem_we    = (r_state == c_ST_WRITE);
    assign busy      = (r_state == c_ST_LOAD) || (r_state == c_ST_WRITE);
    assign done      = (r_state == c_ST_DONE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign err       = r_err;
    assign count     = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_addr  <= '0;
            r_count <= '0;
            r_wdata <= 32'h0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_addr  <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                        r_state <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    if (in_valid) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                            if (in_last) begin
                                r_state <= c_ST_DONE;
                            end
                        end else begin
                            r_wdata <= w_word;
                            r_last  <= in_last;
                            r_state <= c_ST_WRITE;
                        end
                    end
                end
                c_ST_WRITE: begin
                    r_count <= r_count + 1'b1;
                    // Address holds at the top word rather than wrapping to 0
                    if (r_addr != c_LAST_ADDR) begin
                        r_addr <= r_addr + 1'b1;
                    end
                    if (r_last) begin
                        r_state <= c_ST_DONE;
                    end else if (r_addr == c_LAST_ADDR) begin
                        r_err   <= 1'b1;
                        r_state <= c_ST_DONE;
                    end else begin
                        r_state <= c_ST_LOAD;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_loader
// Description : Randomised scoreboard bench for inst_loader (ADDR_W = 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_op = 4'd0;
    logic [4:0]    in_rs = 5'd0;
    logic [4:0]    in_rt = 5'd0;
    logic [4:0]    in_rd = 5'd0;
    logic [15:0]   in_imm = 16'd0;
    logic [25:0]   in_target = 26'd0;
    logic          in_last = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   count;

    inst_loader #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t expq[$];
    int  errors = 0;
    int  checks = 0;
    int  m_cnt  = 0;
    bit  m_err  = 1'b0;
    bit  m_over = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding taken directly from the instruction-format table
    function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm, input logic [25:0] tgt);
        logic [5:0] fn;
        logic [5:0] opc;
        fn  = 6'h00;
        opc = 6'h00;
        case (op)
            4'd1: fn = 6'h20;
            4'd2: fn = 6'h22;
            4'd3: fn = 6'h24;
            4'd4: fn = 6'h25;
            4'd5: fn = 6'h2A;
            4'd6: opc = 6'h23;
            4'd7: opc = 6'h2B;
            4'd8: opc = 6'h08;
            4'd9: opc = 6'h0C;
            4'd11: opc = 6'h04;
            4'd12: opc = 6'h05;
            default: ;
        endcase
        if (op == 4'd0)
            return 32'h0;
        else if (op <= 4'd5)
            return {6'h00, rs, rt, rd, 5'h00, fn};
        else if (op == 4'd10)
            return {6'h02, tgt};
        else
            return {opc, rs, rt, imm};
    endfunction

    task automatic do_start(input bit with_valid);
        @(negedge clk);
        start = 1'b1;
        if (with_valid) begin
            in_valid = 1'b1;
            in_op    = 4'd1;
            in_last  = 1'b1;
        end
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
        m_cnt    = 0;
        m_err    = 1'b0;
        m_over   = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        chk("count_cleared", count, 0);
        chk("err_cleared", err, 0);
    endtask

    task automatic issue(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                         input logic last, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
        while (!in_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("handshake_timeout", 0, 1);
            in_valid = 1'b0;
            m_over   = 1'b1;
            return;
        end
        if (op > 4'd12) begin
            m_err = 1'b1;
            if (last) m_over = 1'b1;
        end else begin
            expq.push_back({m_cnt[AW-1:0], ref_word(op, rs, rt, rd, imm, tgt)});
            m_cnt++;
            if (last) begin
                m_over = 1'b1;
            end else if (m_cnt == DEPTH) begin
                m_err  = 1'b1;
                m_over = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic finish_session();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done", done, 1);
        chk("count", count, m_cnt);
        chk("err", err, m_err);
        chk("busy_in_done", busy, 0);
        chk("queue_drained", expq.size(), 0);
        expq.delete();
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (mem_we === 1'b1) begin
                    wr_t e;
                    if (expq.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        e = expq.pop_front();
                        chk("wr_addr", mem_addr, e.addr);
                        chk("wr_data", mem_wdata, e.data);
                        chk("ready_low_in_write", in_ready, 0);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_count", count, 0);

        // start with in_valid in IDLE: fields must not be taken that cycle
        do_start(1'b1);
        issue(4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 0);
        finish_session();

        // DONE -> start rewrites address 0
        do_start(1'b0);
        issue(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 0);
        finish_session();

        do_start(1'b0);
        issue(4'd6,  5'd0, 5'd2, 5'd0, 16'h0004, 26'h0, 1'b0, 0);
        issue(4'd9,  5'd4, 5'd5, 5'd0, 16'h00FF, 26'h0, 1'b0, 0);
        issue(4'd11, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b0, 0);
        issue(4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 0);
        finish_session();

        do_start(1'b0);
        issue(4'd1,  5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b0, 0);
        issue(4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 1'b0, 0);
        issue(4'd0,  5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, 0);
        finish_session();

        // Truncation: a fifth instruction offered after the memory is full
        do_start(1'b0);
        for (int i = 0; i < DEPTH; i++)
            issue(4'd8, 5'(i), 5'(i + 1), 5'd0, 16'(i * 3), 26'h0, 1'b0, 0);
        @(negedge clk);
        in_op = 4'd1; in_last = 1'b0; in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no_accept_after_full", in_ready, 0);
        end
        in_valid = 1'b0;
        finish_session();

        // Reset the cycle after a handshake drops the pending write
        do_start(1'b0);
        @(negedge clk);
        in_op = 4'd1; in_rs = 5'd5; in_rt = 5'd6; in_rd = 5'd7; in_last = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_addr", mem_addr, 0);
        chk("midrst_wdata", mem_wdata, 0);
        chk("midrst_count", count, 0);
        rst = 1'b0;
        do_start(1'b0);
        issue(4'd4, 5'd3, 5'd4, 5'd5, 16'h0, 26'h0, 1'b1, 0);
        finish_session();

        for (int s = 0; s < 40; s++) begin
            int n;
            n = 0;
            do_start(1'b0);
            while (!m_over) begin
                logic [3:0] op;
                logic       last;
                op   = 4'($urandom_range(0, 15));
                last = ($urandom_range(0, 4) == 0) || (n == 30);
                issue(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
                      26'($urandom), last, $urandom_range(0, 2));
                n++;
            end
            finish_session();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
